// File: rtl/alu_result_fifo.sv
// Show-ahead result FIFO between an ALU and its consumer. Words that arrive while
// full with no pop are dropped and counted, because the ALU cannot be stalled.
module alu_result_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            valid_i,
  input  logic [2*DATA_WIDTH-1:0]         data_i,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic [2*DATA_WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH+1)-1:0]      count_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic                            overflow_o,
  output logic [7:0]                      drop_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int RES_W = 2*DATA_WIDTH;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [RES_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic             push, pop, drop, is_full, is_empty;

  always_comb begin
    is_full    = (count_q == FULL_CNT);
    is_empty   = (count_q == '0);
    pop        = !is_empty && ready_i;
    push       = valid_i && (!is_full || pop);
    drop       = valid_i && is_full && !pop;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    // Power-of-two depth lets the pointers wrap naturally; count alone decides full/empty.
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is data-only; a write during reset is harmless since the pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  always_comb begin
    valid_o    = !is_empty;
    empty_o    = is_empty;
    full_o     = is_full;
    count_o    = count_q;
    overflow_o = overflow_q;
    drop_cnt_o = drop_cnt_q;
    data_o     = is_empty ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed and scoreboarded bench for alu_result_fifo at DATA_WIDTH=8, DEPTH=4.
module tb_alu_result_fifo;

  logic        clk = 1'b0;
  logic        rst, valid_i, ready_i;
  logic [15:0] data_i;
  logic        valid_o, full_o, empty_o, overflow_o;
  logic [15:0] data_o;
  logic [2:0]  count_o;
  logic [7:0]  drop_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  alu_result_fifo #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
    .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] sb [$];
  int          exp_drop;
  logic        exp_ovf;
  logic        m_pop, m_push, m_drop;

  initial begin
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", valid_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_drop", drop_cnt_o, 0);

    // single word
    valid_i = 1'b1; data_i = 16'h1234;
    chk("no_passthru", valid_o, 0);
    step();
    valid_i = 1'b0;
    chk("single_valid", valid_o, 1);
    chk("single_data", data_o, 16'h1234);
    chk("single_count", count_o, 1);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    chk("single_empty", empty_o, 1);
    chk("single_data0", data_o, 0);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    chk("rdy_empty_count", count_o, 0);
    chk("rdy_empty_empty", empty_o, 1);

    // fill, drop, drain
    for (int i = 1; i <= 4; i++) begin
      valid_i = 1'b1; data_i = 16'(i);
      step();
    end
    chk("fill_full", full_o, 1);
    chk("fill_count", count_o, 4);
    chk("fill_head", data_o, 16'h0001);
    data_i = 16'h0005;
    step();
    valid_i = 1'b0;
    chk("drop_ovf", overflow_o, 1);
    chk("drop_cnt1", drop_cnt_o, 1);
    chk("drop_count", count_o, 4);
    chk("drop_head", data_o, 16'h0001);
    ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", data_o, 32'(i));
      step();
    end
    ready_i = 1'b0;
    chk("drain_empty", empty_o, 1);

    // full with simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1; data_i = 16'h0010 + 16'(i);
      step();
    end
    data_i = 16'hAAAA; ready_i = 1'b1;
    step();
    valid_i = 1'b0; ready_i = 1'b0;
    chk("pp_count", count_o, 4);
    chk("pp_drop", drop_cnt_o, 1);
    ready_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      chk("pp_order", data_o, 32'h0010 + 32'(i));
      step();
    end
    ready_i = 1'b0;
    chk("pp_last", data_o, 16'hAAAA);
    chk("pp_last_count", count_o, 1);

    // refill and saturate the drop counter
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1; data_i = 16'h0020 + 16'(i);
      step();
    end
    chk("sat_full", full_o, 1);
    for (int i = 0; i < 300; i++) begin
      data_i = 16'(i);
      step();
    end
    valid_i = 1'b0;
    chk("sat_drop", drop_cnt_o, 255);
    chk("sat_ovf", overflow_o, 1);
    chk("sat_head", data_o, 16'hAAAA);

    // reset mid-operation with 3 entries stored
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    chk("pre_rst_count", count_o, 3);
    rst = 1'b1; valid_i = 1'b1; data_i = 16'hBEEF;
    step();
    rst = 1'b0; data_i = 16'h5A5A;
    chk("mrst_count", count_o, 0);
    chk("mrst_valid", valid_o, 0);
    chk("mrst_ovf", overflow_o, 0);
    chk("mrst_drop", drop_cnt_o, 0);
    chk("mrst_data", data_o, 0);
    step();
    valid_i = 1'b0;
    chk("post_rst_valid", valid_o, 1);
    chk("post_rst_data", data_o, 16'h5A5A);
    chk("post_rst_count", count_o, 1);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    chk("post_rst_empty", empty_o, 1);

    // wrap-around with continuous push and ready
    ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      valid_i = 1'b1; data_i = 16'(i);
      step();
      chk("wrap_data", data_o, 32'(i));
      chk("wrap_count", count_o, 1);
    end
    valid_i = 1'b0;
    step();
    ready_i = 1'b0;
    chk("wrap_empty", empty_o, 1);

    // random traffic against a queue model
    exp_drop = 0;
    exp_ovf  = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      valid_i = ($urandom_range(0, 99) < 70);
      ready_i = ($urandom_range(0, 99) < 50);
      data_i  = 16'($urandom);
      chk("rnd_count", count_o, sb.size());
      chk("rnd_data", data_o, (sb.size() != 0) ? sb[0] : 16'h0000);
      chk("rnd_drop", drop_cnt_o, exp_drop);
      chk("rnd_ovf", overflow_o, exp_ovf);
      m_pop  = (sb.size() != 0) && ready_i;
      m_push = valid_i && ((sb.size() < 4) || m_pop);
      m_drop = valid_i && !m_push;
      if (m_drop) begin
        chk("rnd_drop_full", count_o, 4);
        chk("rnd_drop_nopop", {31'd0, valid_o && ready_i}, 0);
        if (exp_drop < 255) exp_drop++;
        exp_ovf = 1'b1;
      end
      if (m_pop)  void'(sb.pop_front());
      if (m_push) sb.push_back(data_i);
      step();
    end
    valid_i = 1'b0; ready_i = 1'b0;
    chk("rnd_final_count", count_o, sb.size());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
